chip_74161_ctrl: RTL and testbench
==================================

Name: chip_74161_ctrl

Overview:
- Test sequencer for a 74161 4-bit synchronous binary counter in a DIP-16 socket.
- Drives every chip input pin, generates the chip clock, and samples the chip outputs through synchronizers.
- Compares the sampled outputs against an internal expected-count model and reports pass/fail through Done/RSLT to the checker top level.

Parameters:
- SETTLE_CYC, 4: Clk cycles held in each drive phase before the next phase. Minimum 3, which covers the synchronizer latency plus external propagation.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  start request (level).
- Pin1  out  1  CLR_n.
- Pin2  out  1  chip CLK.
- Pin3..Pin6  out  1 each  data A..D (A = LSB).
- Pin7  out  1  ENP.
- Pin9  out  1  LOAD_n.
- Pin10  out  1  ENT.
- Pin14, Pin13, Pin12, Pin11  in  1 each  QA, QB, QC, QD (QA = LSB).
- Pin15  in  1  RCO.
- Done  out  1  test complete.
- RSLT  out  1  pass indication.
- DISP_RSLT  in  1  result display enable.

Behaviour:
- Reset values (asynchronous, on Reset=0): Pin1=1, Pin2=0, Pin3..6=0, Pin7=0, Pin9=1, Pin10=0, Done=0, RSLT=0.
  - Internal state returns to IDLE; pass flag=1; synchronizers cleared.
  - Reset mid-test aborts immediately.
- Input synchronization: Pin11..15 pass through 2-FF synchronizers. All checks use the synchronized values sampled at the end of the final settle phase.
- FSM states: IDLE, SETUP, CLK_HI, CLK_LO, CHECK, NEXT, DONE.
  - IDLE: Run=1 moves to SETUP with load index li=0 and op=CLEAR.
  - SETUP: drive the pin pattern for the current op and hold SETTLE_CYC cycles.
    - Ops with a clock pulse go to CLK_HI.
    - CLEAR and ENT_OFF go directly to CHECK.
  - CLK_HI: Pin2=1 for SETTLE_CYC cycles, then CLK_LO.
  - CLK_LO: Pin2=0 for SETTLE_CYC cycles, then CHECK.
  - CHECK (1 cycle): compare {QD,QC,QB,QA} and RCO with expected values.
    - Mismatch: pass=0, go to DONE (early abort).
    - Match: go to NEXT.
  - NEXT (1 cycle): advance op/count/li. After the last op of li=3, go to DONE.
  - DONE: Done=1. Run ignored until low; Run=0 returns to IDLE with Done=0 the following cycle.
    - Run held high stays in DONE (no auto-restart).
- Run deasserted mid-test is ignored; the test runs to completion.
- Op sequence per load value L = LOAD_VALS[li], where LOAD_VALS = {0x0, 0x5, 0xA, 0xF}:
  - CLEAR: Pin1=0, LOAD_n=1, ENP=ENT=0. Expect Q=0, RCO=0. Pin1 returns to 1 in NEXT.
  - LOAD: LOAD_n=0, D=L, ENP=ENT=0, one pulse. Expect Q=L, RCO=0.
  - COUNT k=1..16: LOAD_n=1, ENP=ENT=1, one pulse each.
    - Expect Q=(L+k) mod 16 (4-bit wrap).
    - Expect RCO=(Q==0xF).
  - HOLD x2: ENP=0, ENT=1, one pulse each. Expect Q unchanged, RCO=(Q==0xF).
  - ENT_OFF: ENP=0, ENT=0, no pulse. Expect Q unchanged, RCO=0.
- Check count: 21 checks per L, 84 total. The expected model is a 4-bit register updated in NEXT.
- RSLT = Done & DISP_RSLT & pass. It is 0 whenever not in DONE.
- Latency: Done asserts no later than 84*(3*SETTLE_CYC+2) Clk cycles after Run is sampled in IDLE (1176 cycles for SETTLE_CYC=4).

Decomposition:
- Package chip_74161_pkg contains:
  - state_t enum;
  - op_t enum (CLEAR, LOAD, COUNT, HOLD, ENT_OFF);
  - LOAD_VALS constant array;
  - COUNT_STEPS=16, HOLD_STEPS=2.
- Sub-module sync_2ff: a parameterized-width 2-flop synchronizer with active-low asynchronous reset, instantiated once at width 5.

Test Plan:
- Good behavioural 74161 model, SETTLE_CYC=4, DISP_RSLT=1, Run=1.
  - Required: Done=1 within 1176 cycles; RSLT=1.
  - Toggling DISP_RSLT to 0 forces RSLT=0 while Done stays 1.
- QB stuck at 0, Run=1.
  - Required: abort at COUNT k=2 of L=0x0 (expected 0x2).
  - Done=1, RSLT=0; no further Pin2 pulses after Done.
- RCO tied 0.
  - Required: pass through k=1..14 of L=0x0, fail at k=15 (Q=0xF).
  - Done=1, RSLT=0.
- Model ignores ENP (counts while ENP=0).
  - Required: first HOLD check of L=0x0 fails (expected 0x0, got 0x1).
  - Done=1, RSLT=0.
- Reset=0 asserted during COUNT of L=0x5.
  - Required: same-cycle Pin2=0, Pin1=1, Pin9=1, Done=0.
  - After release and Run=1, the full good-chip run passes.
- Run held 1 after Done.
  - Required: FSM stays in DONE; Run=0 gives Done=0 one cycle later.
  - Run=1 again restarts with the CLEAR op (Pin1=0 observed).

Source files
------------

// File: rtl/chip_74161_pkg.sv
// Shared types and constants for the 74161 counter test sequencer.
//   state_t   : sequencer FSM states
//   op_t      : chip operations applied in order for every load value
//   pins_t    : static drive pattern for CLR_n, LOAD_n, ENP, ENT and D[3:0]
//   LOAD_VALS : values loaded into the chip, one full op sequence each
package chip_74161_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CLK_HI,
        ST_CLK_LO,
        ST_CHECK,
        ST_NEXT,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_CLEAR,
        OP_LOAD,
        OP_COUNT,
        OP_HOLD,
        OP_ENT_OFF
    } op_t;

    typedef struct packed {
        logic       clr_n;
        logic       load_n;
        logic       enp;
        logic       ent;
        logic [3:0] data;
    } pins_t;

    localparam int NUM_LOADS   = 4;
    localparam int COUNT_STEPS = 16;
    localparam int HOLD_STEPS  = 2;

    localparam logic [3:0] LOAD_VALS [NUM_LOADS] = '{4'h0, 4'h5, 4'hA, 4'hF};

    // Pattern driven while no op is in progress: chip not cleared, not
    // loading, counting disabled.
    localparam pins_t IDLE_PINS = '{clr_n: 1'b1, load_n: 1'b1, enp: 1'b0,
                                    ent: 1'b0, data: 4'h0};

    // CLEAR and ENT_OFF are checked without a clock pulse.
    function automatic logic op_has_pulse(input op_t op);
        return (op == OP_LOAD) || (op == OP_COUNT) || (op == OP_HOLD);
    endfunction

    // Drive pattern for one op; the data bus always carries the current
    // load value so that only LOAD_n decides whether it is captured.
    function automatic pins_t op_pins(input op_t op, input logic [3:0] load_val);
        pins_t p;
        p      = IDLE_PINS;
        p.data = load_val;
        case (op)
            OP_CLEAR: p.clr_n  = 1'b0;
            OP_LOAD:  p.load_n = 1'b0;
            OP_COUNT: begin
                p.enp = 1'b1;
                p.ent = 1'b1;
            end
            OP_HOLD:  p.ent    = 1'b1;
            default:  ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/chip_74161_ctrl_sync.sv
// Parameterized-width two-flop synchronizer.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous inputs
//   q     : synchronized outputs (two clk cycles of latency)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/chip_74161_ctrl.sv
// Test sequencer for a 74161 4-bit synchronous counter in a DIP-16 socket.
// Drives all chip inputs, generates the chip clock on Pin2, samples the
// chip outputs through a 2-FF synchronizer and compares them against an
// internal expected-count model, aborting on the first mismatch.
//   Clk        : system clock
//   Reset      : asynchronous active-low reset
//   Run        : start request (level); ignored while a test is running
//   Pin1       : CLR_n          Pin2      : chip CLK
//   Pin3..Pin6 : D A..D (A=LSB) Pin7      : ENP
//   Pin9       : LOAD_n         Pin10     : ENT
//   Pin14..11  : QA..QD in      Pin15     : RCO in
//   Done       : test complete  RSLT      : pass, gated by DISP_RSLT
//   DISP_RSLT  : result display enable
module chip_74161_ctrl
    import chip_74161_pkg::*;
#(
    parameter int SETTLE_CYC = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    output logic Pin1,
    output logic Pin2,
    output logic Pin3,
    output logic Pin4,
    output logic Pin5,
    output logic Pin6,
    output logic Pin7,
    output logic Pin9,
    output logic Pin10,
    input  logic Pin11,
    input  logic Pin12,
    input  logic Pin13,
    input  logic Pin14,
    input  logic Pin15,
    output logic Done,
    output logic RSLT,
    input  logic DISP_RSLT
);

    localparam int             SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYC - 1);

    state_t     state_reg,   state_next;
    op_t        op_reg,      op_next;
    logic [1:0] li_reg,      li_next;
    logic [3:0] step_reg,    step_next;
    logic [SW-1:0] settle_reg, settle_next;
    logic [3:0] model_q_reg, model_q_next;
    logic       pass_reg,    pass_next;
    pins_t      pins_reg,    pins_next;
    logic       pin2_reg,    pin2_next;
    logic       done_reg,    done_next;

    logic [4:0] raw_in;
    logic [4:0] sync_out;
    logic [3:0] sync_q;
    logic       sync_rco;
    logic [3:0] exp_q;
    logic       exp_rco;
    logic       phase_end;

    // Bit 4 is RCO, bits 3..0 are QD..QA.
    assign raw_in = {Pin15, Pin11, Pin12, Pin13, Pin14};

    sync_2ff #(.WIDTH(5)) u_sync (
        .clk   (Clk),
        .rst_n (Reset),
        .d     (raw_in),
        .q     (sync_out)
    );

    assign sync_q   = sync_out[3:0];
    assign sync_rco = sync_out[4];

    // Expected chip response to the op currently being applied. The model
    // register holds the count after the previous op and is advanced in NEXT.
    always_comb begin
        exp_q = model_q_reg;
        case (op_reg)
            OP_CLEAR: exp_q = 4'h0;
            OP_LOAD:  exp_q = LOAD_VALS[li_reg];
            OP_COUNT: exp_q = model_q_reg + 4'd1;
            default:  exp_q = model_q_reg;
        endcase
    end

    // RCO is gated by ENT, which is only high during COUNT and HOLD.
    assign exp_rco   = ((op_reg == OP_COUNT) || (op_reg == OP_HOLD)) && (exp_q == 4'hF);
    assign phase_end = (settle_reg == SETTLE_LAST);

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        li_next      = li_reg;
        step_next    = step_reg;
        settle_next  = settle_reg;
        model_q_next = model_q_reg;
        pass_next    = pass_reg;

        case (state_reg)
            ST_IDLE: begin
                if (Run) begin
                    state_next  = ST_SETUP;
                    op_next     = OP_CLEAR;
                    li_next     = 2'd0;
                    step_next   = 4'd0;
                    settle_next = '0;
                    pass_next   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (phase_end) begin
                    settle_next = '0;
                    state_next  = op_has_pulse(op_reg) ? ST_CLK_HI : ST_CHECK;
                end else begin
                    settle_next = settle_reg + 1'b1;
                end
            end
            ST_CLK_HI: begin
                if (phase_end) begin
                    settle_next = '0;
                    state_next  = ST_CLK_LO;
                end else begin
                    settle_next = settle_reg + 1'b1;
                end
            end
            ST_CLK_LO: begin
                if (phase_end) begin
                    settle_next = '0;
                    state_next  = ST_CHECK;
                end else begin
                    settle_next = settle_reg + 1'b1;
                end
            end
            ST_CHECK: begin
                if ((sync_q == exp_q) && (sync_rco == exp_rco)) begin
                    state_next = ST_NEXT;
                end else begin
                    pass_next  = 1'b0;
                    state_next = ST_DONE;
                end
            end
            ST_NEXT: begin
                model_q_next = exp_q;
                state_next   = ST_SETUP;
                case (op_reg)
                    OP_CLEAR: op_next = OP_LOAD;
                    OP_LOAD: begin
                        op_next   = OP_COUNT;
                        step_next = 4'd0;
                    end
                    OP_COUNT: begin
                        if (step_reg == 4'(COUNT_STEPS - 1)) begin
                            op_next   = OP_HOLD;
                            step_next = 4'd0;
                        end else begin
                            step_next = step_reg + 4'd1;
                        end
                    end
                    OP_HOLD: begin
                        if (step_reg == 4'(HOLD_STEPS - 1)) begin
                            op_next   = OP_ENT_OFF;
                            step_next = 4'd0;
                        end else begin
                            step_next = step_reg + 4'd1;
                        end
                    end
                    default: begin
                        if (li_reg == 2'(NUM_LOADS - 1)) begin
                            state_next = ST_DONE;
                        end else begin
                            li_next = li_reg + 2'd1;
                            op_next = OP_CLEAR;
                        end
                    end
                endcase
            end
            ST_DONE: begin
                // Only a low Run re-arms the sequencer; no auto-restart.
                if (!Run) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so they change cleanly
    // on Clk and line up with the state they belong to. The op pattern is
    // held through CHECK; NEXT drops back to the idle pattern (CLR_n high).
    always_comb begin
        pins_next = IDLE_PINS;
        if ((state_next == ST_SETUP) || (state_next == ST_CLK_HI) ||
            (state_next == ST_CLK_LO) || (state_next == ST_CHECK)) begin
            pins_next = op_pins(op_next, LOAD_VALS[li_next]);
        end
        pin2_next = (state_next == ST_CLK_HI);
        done_next = (state_next == ST_DONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_CLEAR;
            li_reg      <= 2'd0;
            step_reg    <= 4'd0;
            settle_reg  <= '0;
            model_q_reg <= 4'h0;
            pass_reg    <= 1'b1;
            pins_reg    <= IDLE_PINS;
            pin2_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            li_reg      <= li_next;
            step_reg    <= step_next;
            settle_reg  <= settle_next;
            model_q_reg <= model_q_next;
            pass_reg    <= pass_next;
            pins_reg    <= pins_next;
            pin2_reg    <= pin2_next;
            done_reg    <= done_next;
        end
    end

    assign Pin1  = pins_reg.clr_n;
    assign Pin2  = pin2_reg;
    assign Pin3  = pins_reg.data[0];
    assign Pin4  = pins_reg.data[1];
    assign Pin5  = pins_reg.data[2];
    assign Pin6  = pins_reg.data[3];
    assign Pin7  = pins_reg.enp;
    assign Pin9  = pins_reg.load_n;
    assign Pin10 = pins_reg.ent;
    assign Done  = done_reg;
    assign RSLT  = done_reg & DISP_RSLT & pass_reg;

endmodule

// File: tb/tb_chip_74161_ctrl.sv
// Self-checking bench for chip_74161_ctrl with a behavioural 74161 in the
// socket and selectable chip faults. Each test run pushes its expected
// outcome (pass flag, pulse and clear counts) to a scoreboard; a monitor
// pops and compares when Done rises.
module tb_chip_74161_ctrl;

    localparam int SETTLE  = 4;
    localparam int LAT_MAX = 84 * (3 * SETTLE + 2);

    // Fault modes of the chip model.
    localparam int F_GOOD    = 0;
    localparam int F_STUCK   = 1;   // one Q output stuck at a value
    localparam int F_RCO0    = 2;   // RCO tied low
    localparam int F_IGN_ENP = 3;   // counts whenever ENT is high
    localparam int F_RCO1    = 4;   // RCO tied high

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Run = 1'b0;
    logic DISP_RSLT = 1'b1;
    logic Pin1, Pin2, Pin3, Pin4, Pin5, Pin6, Pin7, Pin9, Pin10;
    logic Pin11, Pin12, Pin13, Pin14, Pin15;
    logic Done, RSLT;

    chip_74161_ctrl #(.SETTLE_CYC(SETTLE)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run),
        .Pin1(Pin1), .Pin2(Pin2), .Pin3(Pin3), .Pin4(Pin4), .Pin5(Pin5),
        .Pin6(Pin6), .Pin7(Pin7), .Pin9(Pin9), .Pin10(Pin10),
        .Pin11(Pin11), .Pin12(Pin12), .Pin13(Pin13), .Pin14(Pin14),
        .Pin15(Pin15), .Done(Done), .RSLT(RSLT), .DISP_RSLT(DISP_RSLT)
    );

    always #5 Clk = ~Clk;

    // ---------------- behavioural 74161 with fault injection -------------
    int         fault = F_GOOD;
    logic [1:0] stuck_bit = 2'd0;
    logic       stuck_val = 1'b0;
    logic [3:0] cq = 4'h0;
    logic [3:0] q_obs;

    always @(posedge Pin2 or negedge Pin1) begin
        if (!Pin1)
            cq <= 4'h0;
        else if (!Pin9)
            cq <= {Pin6, Pin5, Pin4, Pin3};
        else if (Pin10 && (Pin7 || fault == F_IGN_ENP))
            cq <= cq + 4'd1;
    end

    always_comb begin
        q_obs = cq;
        if (fault == F_STUCK) q_obs[stuck_bit] = stuck_val;
    end

    assign Pin14 = q_obs[0];
    assign Pin13 = q_obs[1];
    assign Pin12 = q_obs[2];
    assign Pin11 = q_obs[3];
    assign Pin15 = (fault == F_RCO0) ? 1'b0 :
                   (fault == F_RCO1) ? 1'b1 : (Pin10 && cq == 4'hF);

    // ---------------- free-running observers ------------------------------
    int   cyc = 0;
    int   pulse_cnt = 0;
    int   clear_cnt = 0;
    logic p2_d = 1'b0;
    logic p1_d = 1'b1;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        p2_d <= Pin2;
        p1_d <= Pin1;
        if (Pin2 && !p2_d) pulse_cnt <= pulse_cnt + 1;
        if (!Pin1 && p1_d) clear_cnt <= clear_cnt + 1;
    end

    // ---------------- scoreboard ------------------------------------------
    typedef struct {
        bit pass;
        bit disp;
        int pulses;
        int clears;
        int base_p;
        int base_c;
        int start_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_cnt = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: walks the test plan op by op, applying the faulty
    // chip's behaviour and the ideal expectation, and stops at the first
    // observable mismatch.
    function automatic void ref_run(input int f, input logic [1:0] sb,
                                    input logic sv, output bit pass,
                                    output int pulses, output int clears);
        int         lv[4] = '{0, 5, 10, 15};
        logic [3:0] q;
        logic [3:0] e;
        logic [3:0] qo;
        logic       ro;
        logic       er;
        bit         ent;
        pass = 1; pulses = 0; clears = 0;
        q = 4'h0; e = 4'h0;
        for (int li = 0; li < 4; li++) begin
            for (int j = 0; j < 21; j++) begin
                ent = 0;
                if (j == 0) begin
                    q = 4'h0; e = 4'h0; clears++;
                end else if (j == 1) begin
                    q = 4'(lv[li]); e = 4'(lv[li]); pulses++;
                end else if (j < 18) begin
                    ent = 1; q = q + 4'd1; e = e + 4'd1; pulses++;
                end else if (j < 20) begin
                    ent = 1; pulses++;
                    if (f == F_IGN_ENP) q = q + 4'd1;
                end
                er = ent && (e == 4'hF);
                qo = q;
                if (f == F_STUCK) qo[sb] = sv;
                ro = (f == F_RCO0) ? 1'b0 : (f == F_RCO1) ? 1'b1 : (ent && q == 4'hF);
                if (qo != e || ro != er) begin
                    pass = 0;
                    return;
                end
            end
        end
    endfunction

    // Monitor: on each rising Done, pop one expectation and compare.
    initial begin : monitor
        bit   done_d;
        exp_t e;
        int   lat;
        done_d = 0;
        forever begin
            @(negedge Clk);
            if (Done && !done_d && Reset) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got 1 expected 0");
                end else begin
                    e = sb_q.pop_front();
                    lat = cyc - e.start_cyc;
                    $display("run %0d: rslt=%0d pulses=%0d clears=%0d latency=%0d",
                             mon_cnt, RSLT, pulse_cnt - e.base_p,
                             clear_cnt - e.base_c, lat);
                    check("rslt", int'(RSLT), int'(e.pass & e.disp));
                    check("pulses", pulse_cnt - e.base_p, e.pulses);
                    check("clears", clear_cnt - e.base_c, e.clears);
                    checks++;
                    if (lat > LAT_MAX) begin
                        errors++;
                        $display("FAIL latency got %0d cycles required <= %0d", lat, LAT_MAX);
                    end
                end
                mon_cnt++;
            end
            done_d = Done;
        end
    end

    // ---------------- stimulus --------------------------------------------
    task automatic run_test(input int f, input logic [1:0] sb, input logic sv,
                            input logic disp, input bit hold_run);
        exp_t e;
        int   prev;
        bit   seen;
        @(negedge Clk);
        fault = f; stuck_bit = sb; stuck_val = sv; DISP_RSLT = disp;
        ref_run(f, sb, sv, e.pass, e.pulses, e.clears);
        e.disp = disp;
        e.base_p = pulse_cnt;
        e.base_c = clear_cnt;
        e.start_cyc = cyc;
        sb_q.push_back(e);
        prev = mon_cnt;
        Run = 1'b1;
        seen = 0;
        for (int i = 0; i < LAT_MAX + 50; i++) begin
            @(negedge Clk);
            if (i == 10 && !hold_run) Run = 1'b0;   // ignored mid-test
            if (mon_cnt != prev) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout got 0 expected 1");
            sb_q.delete();
        end
        if (seen && hold_run) begin
            repeat (20) @(negedge Clk);
            check("done_held", int'(Done), 1);
            check("no_pulse_after_done", pulse_cnt - e.base_p, e.pulses);
            DISP_RSLT = 1'b0;
            #1;
            check("rslt_disp_off", int'(RSLT), 0);
            check("done_disp_off", int'(Done), 1);
            DISP_RSLT = disp;
            #1;
            check("rslt_disp_back", int'(RSLT), int'(e.pass & disp));
        end
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);
        check("done_clear", int'(Done), 0);
        repeat (2) @(negedge Clk);
    endtask

    task automatic reset_mid_count();
        int  base;
        bit  hit;
        @(negedge Clk);
        fault = F_GOOD; DISP_RSLT = 1'b1;
        base = pulse_cnt;
        Run = 1'b1;
        hit = 0;
        // 19 pulses for L=0x0, then LOAD of 0x5: pulse 25 is inside COUNT.
        for (int i = 0; i < LAT_MAX; i++) begin
            @(negedge Clk);
            if (Pin2 && (pulse_cnt - base) >= 25) begin
                hit = 1;
                break;
            end
        end
        check("reach_count_l5", int'(hit), 1);
        #1 Reset = 1'b0;
        #1;
        check("rst_mid_pins", int'({Pin2, Pin1, Pin9, Done}), int'(4'b0110));
        $display("reset asserted mid-count at cycle %0d", cyc);
        Run = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_hold_done", int'(Done), 0);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        #2 Reset = 1'b0;
        #1;
        check("reset_outputs",
              int'({Pin1, Pin2, Pin3, Pin4, Pin5, Pin6, Pin7, Pin9, Pin10, Done, RSLT}),
              int'(11'b1_0_0000_0_1_0_0_0));
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        run_test(F_GOOD,    2'd0, 1'b0, 1'b1, 1'b1);
        run_test(F_STUCK,   2'd1, 1'b0, 1'b1, 1'b1);   // QB stuck at 0
        run_test(F_RCO0,    2'd0, 1'b0, 1'b1, 1'b1);
        run_test(F_IGN_ENP, 2'd0, 1'b0, 1'b1, 1'b1);
        reset_mid_count();
        run_test(F_GOOD,    2'd0, 1'b0, 1'b1, 1'b1);
        run_test(F_RCO1,    2'd0, 1'b0, 1'b1, 1'b0);

        for (int n = 0; n < 8; n++) begin
            run_test(int'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                     bit'($urandom_range(0, 1)));
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
